// File: rtl/rv_arbiter.sv
// rv_arbiter: three-way round-robin arbiter with burst-locked grants.
// A grant is held until the requester marks its last beat or BURST_MAX
// beats have been transferred. The datapath is purely combinational
// from the granted requester to the output, so nothing is ever buffered.
module rv_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    input  logic                  in0_last,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    input  logic                  in1_last,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in2_data,
    input  logic                  in2_valid,
    input  logic                  in2_last,
    output logic                  in2_ready,
    output logic [DATA_WIDTH-1:0] output_port_data,
    output logic                  output_port_valid,
    input  logic                  output_port_ready,
    output logic [1:0]            output_port_source
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Count value of the final beat allowed in one grant.
    localparam logic [3:0] COUNT_LAST = 4'(BURST_MAX - 1);

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0]      count_q, count_d;

    logic [1:0]            cand0_s, cand1_s, cand2_s;
    logic [1:0]            pick_s;
    logic                  any_valid_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic                  beat_s;
    logic                  burst_end_s;

    // Modulo-3 successor; an illegal index folds back to requester 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Valid flag of requester idx; an illegal index reads as not valid.
    function automatic logic valid_of(input logic [1:0] idx, input logic v0,
                                      input logic v1, input logic v2);
        case (idx)
            2'd0:    return v0;
            2'd1:    return v1;
            2'd2:    return v2;
            default: return 1'b0;
        endcase
    endfunction

    // Round-robin scan starting at the pointer: ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        cand0_s     = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        cand1_s     = next_idx(cand0_s);
        cand2_s     = next_idx(cand1_s);
        any_valid_s = in0_valid | in1_valid | in2_valid;
        if (valid_of(cand0_s, in0_valid, in1_valid, in2_valid)) begin
            pick_s = cand0_s;
        end else if (valid_of(cand1_s, in0_valid, in1_valid, in2_valid)) begin
            pick_s = cand1_s;
        end else begin
            pick_s = cand2_s;
        end
    end

    // Select the granted requester's payload, valid and last flags.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        case (grant_q)
            2'd0: begin
                sel_data_s  = in0_data;
                sel_valid_s = in0_valid;
                sel_last_s  = in0_last;
            end
            2'd1: begin
                sel_data_s  = in1_data;
                sel_valid_s = in1_valid;
                sel_last_s  = in1_last;
            end
            2'd2: begin
                sel_data_s  = in2_data;
                sel_valid_s = in2_valid;
                sel_last_s  = in2_last;
            end
            default: begin
                sel_data_s  = '0;
                sel_valid_s = 1'b0;
                sel_last_s  = 1'b0;
            end
        endcase
    end

    // Drive the output port and route downstream ready back to the grantee only.
    always_comb begin
        output_port_data  = '0;
        output_port_valid = 1'b0;
        in0_ready         = 1'b0;
        in1_ready         = 1'b0;
        in2_ready         = 1'b0;
        if (state_q == ST_BURST) begin
            output_port_data  = sel_data_s;
            output_port_valid = sel_valid_s;
            case (grant_q)
                2'd0:    in0_ready = output_port_ready;
                2'd1:    in1_ready = output_port_ready;
                2'd2:    in2_ready = output_port_ready;
                default: begin
                    in0_ready = 1'b0;
                    in1_ready = 1'b0;
                    in2_ready = 1'b0;
                end
            endcase
        end else begin
            output_port_data  = '0;
            output_port_valid = 1'b0;
        end
    end

    assign output_port_source = grant_q;
    assign beat_s      = (state_q == ST_BURST) & sel_valid_s & output_port_ready;
    assign burst_end_s = beat_s & (sel_last_s | (count_q == COUNT_LAST));

    // Next-state logic; clear overrides every transition including a last beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear) begin
            state_d = ST_IDLE;
            ptr_d   = 2'd0;
            count_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        state_d = ST_BURST;
                        grant_d = pick_s;
                        count_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (burst_end_s) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_idx(grant_q);
                        count_d = count_q + 4'd1;
                    end else if (beat_s) begin
                        count_d = count_q + 4'd1;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = 2'd0;
                    ptr_d   = 2'd0;
                    count_d = 4'd0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset that abandons any burst at once.
    always_ff @(posedge clock_port or posedge reset_port) begin
        if (reset_port) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule
